// File: rtl/game_flow_fsm.sv
// Pong game sequencer: menu, timed serve, play, pause and game-over with a target-plus-margin win rule.
// Buttons are rising-edge detected (history flops reset high); every output is registered.
module game_flow_fsm #(
  parameter int WIN_SCORE   = 3,
  parameter int WIN_MARGIN  = 1,
  parameter int SCORE_W     = 4,
  parameter int SERVE_TICKS = 60,
  parameter int OVER_TICKS  = 300
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               timing_tick,
  input  logic               start,
  input  logic               pause,
  input  logic               ack,
  input  logic               point_p1,
  input  logic               point_p2,
  output logic [2:0]         state,
  output logic [SCORE_W-1:0] player1_score,
  output logic [SCORE_W-1:0] player2_score,
  output logic [1:0]         winner,
  output logic               serve_dir,
  output logic               round_start
);

  localparam int CNT_MAX = (SERVE_TICKS > OVER_TICKS) ? SERVE_TICKS : OVER_TICKS;
  localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]   SERVE_LOAD = CNT_W'(SERVE_TICKS);
  localparam logic [CNT_W-1:0]   OVER_LOAD  = CNT_W'(OVER_TICKS);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
  localparam logic [SCORE_W-1:0] WIN_SCORE_L  = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] WIN_MARGIN_L = SCORE_W'(WIN_MARGIN);

  typedef enum logic [2:0] {
    ST_MENU  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_OVER  = 3'd3,
    ST_PAUSE = 3'd4
  } state_t;

  state_t             r_state, w_state_nxt;
  state_t             r_ret, w_ret_nxt;
  logic [SCORE_W-1:0] r_p1, w_p1_nxt;
  logic [SCORE_W-1:0] r_p2, w_p2_nxt;
  logic [1:0]         r_winner, w_winner_nxt;
  logic               r_dir, w_dir_nxt;
  logic               r_round, w_round_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_start_q, r_pause_q, r_ack_q;

  logic               w_start_rise, w_pause_rise, w_ack_rise;
  logic               w_one_point;
  logic [SCORE_W-1:0] w_p1_inc, w_p2_inc, w_scr, w_opp;
  logic               w_win;

  assign w_start_rise = start & ~r_start_q;
  assign w_pause_rise = pause & ~r_pause_q;
  assign w_ack_rise   = ack   & ~r_ack_q;

  // Win rule evaluated on the post-increment score of whoever scored this cycle.
  assign w_one_point = point_p1 ^ point_p2;
  assign w_p1_inc    = (r_p1 == SCORE_MAX) ? r_p1 : r_p1 + 1'b1;
  assign w_p2_inc    = (r_p2 == SCORE_MAX) ? r_p2 : r_p2 + 1'b1;
  assign w_scr       = point_p1 ? w_p1_inc : w_p2_inc;
  assign w_opp       = point_p1 ? r_p2 : r_p1;
  assign w_win       = (w_scr >= WIN_SCORE_L) && (w_scr > w_opp) &&
                       ((w_scr - w_opp) >= WIN_MARGIN_L);

  always_comb begin
    w_state_nxt  = r_state;
    w_ret_nxt    = r_ret;
    w_p1_nxt     = r_p1;
    w_p2_nxt     = r_p2;
    w_winner_nxt = r_winner;
    w_dir_nxt    = r_dir;
    w_round_nxt  = 1'b0;
    w_cnt_nxt    = r_cnt;
    case (r_state)
      ST_MENU: begin
        if (w_start_rise) begin
          w_state_nxt  = ST_SERVE;
          w_p1_nxt     = '0;
          w_p2_nxt     = '0;
          w_winner_nxt = 2'd0;
          w_dir_nxt    = 1'b0;
          w_cnt_nxt    = SERVE_LOAD;
        end
      end
      ST_SERVE: begin
        if (w_pause_rise) begin
          w_state_nxt = ST_PAUSE;
          w_ret_nxt   = ST_SERVE;
        end else if (r_cnt == '0) begin
          w_state_nxt = ST_PLAY;
          w_round_nxt = 1'b1;
        end else if (timing_tick) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_PLAY: begin
        // A point outranks a simultaneous pause press, which is then dropped.
        if (w_one_point) begin
          if (point_p1) w_p1_nxt = w_p1_inc;
          else          w_p2_nxt = w_p2_inc;
          w_dir_nxt = point_p1;
          if (w_win) begin
            w_state_nxt  = ST_OVER;
            w_winner_nxt = point_p1 ? 2'd1 : 2'd2;
            w_cnt_nxt    = OVER_LOAD;
          end else begin
            w_state_nxt = ST_SERVE;
            w_cnt_nxt   = SERVE_LOAD;
          end
        end else if (w_pause_rise) begin
          w_state_nxt = ST_PAUSE;
          w_ret_nxt   = ST_PLAY;
        end
      end
      ST_OVER: begin
        if (w_ack_rise) begin
          w_state_nxt = ST_MENU;
        end else if (OVER_TICKS > 0) begin
          if (r_cnt == '0)      w_state_nxt = ST_MENU;
          else if (timing_tick) w_cnt_nxt   = r_cnt - 1'b1;
        end
      end
      ST_PAUSE: begin
        if (w_ack_rise) begin
          w_state_nxt  = ST_MENU;
          w_p1_nxt     = '0;
          w_p2_nxt     = '0;
          w_winner_nxt = 2'd0;
        end else if (w_pause_rise) begin
          w_state_nxt = r_ret;
        end
      end
      default: w_state_nxt = ST_MENU;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_MENU;
      r_ret     <= ST_SERVE;
      r_p1      <= '0;
      r_p2      <= '0;
      r_winner  <= 2'd0;
      r_dir     <= 1'b0;
      r_round   <= 1'b0;
      r_cnt     <= '0;
      r_start_q <= 1'b1;
      r_pause_q <= 1'b1;
      r_ack_q   <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_ret     <= w_ret_nxt;
      r_p1      <= w_p1_nxt;
      r_p2      <= w_p2_nxt;
      r_winner  <= w_winner_nxt;
      r_dir     <= w_dir_nxt;
      r_round   <= w_round_nxt;
      r_cnt     <= w_cnt_nxt;
      r_start_q <= start;
      r_pause_q <= pause;
      r_ack_q   <= ack;
    end
  end

  assign state         = r_state;
  assign player1_score = r_p1;
  assign player2_score = r_p2;
  assign winner        = r_winner;
  assign serve_dir     = r_dir;
  assign round_start   = r_round;

endmodule

// File: tb/tb_game_flow_fsm.sv
// Two sequencer instances (default rule; margin-2 with zero serve/over ticks and 3-bit scores) driven
// by shared stimulus and checked every cycle against a behavioural model, plus literal spot checks.
module tb_game_flow_fsm;

  logic clk = 1'b0;
  logic rst_i = 1'b1, tick_i = 1'b0, start_i = 1'b0, pause_i = 1'b0, ack_i = 1'b0;
  logic p1_i = 1'b0, p2_i = 1'b0;

  logic [2:0] a_state, b_state;
  logic [3:0] a_s1, a_s2;
  logic [2:0] b_s1, b_s2;
  logic [1:0] a_win, b_win;
  logic       a_dir, b_dir, a_rs, b_rs;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  game_flow_fsm dut_a (
    .clk(clk), .rst(rst_i), .timing_tick(tick_i), .start(start_i), .pause(pause_i), .ack(ack_i),
    .point_p1(p1_i), .point_p2(p2_i), .state(a_state), .player1_score(a_s1), .player2_score(a_s2),
    .winner(a_win), .serve_dir(a_dir), .round_start(a_rs)
  );

  game_flow_fsm #(.WIN_SCORE(3), .WIN_MARGIN(2), .SCORE_W(3), .SERVE_TICKS(0), .OVER_TICKS(0)) dut_b (
    .clk(clk), .rst(rst_i), .timing_tick(tick_i), .start(start_i), .pause(pause_i), .ack(ack_i),
    .point_p1(p1_i), .point_p2(p2_i), .state(b_state), .player1_score(b_s1), .player2_score(b_s2),
    .winner(b_win), .serve_dir(b_dir), .round_start(b_rs)
  );

  // Model: states 0 menu, 1 serve, 2 play, 3 game over, 4 pause.
  int p_ws[2]  = '{3, 3};
  int p_wm[2]  = '{1, 2};
  int p_max[2] = '{15, 7};
  int p_srv[2] = '{60, 0};
  int p_ovr[2] = '{300, 0};
  int m_st[2], m_s1[2], m_s2[2], m_win[2], m_dir[2], m_rs[2], m_cnt[2], m_ret[2];
  int pv_st, pv_pa, pv_ak;

  task automatic model_step();
    bit rise_st, rise_pa, rise_ak;
    int a, b;
    if (rst_i) begin
      for (int i = 0; i < 2; i++) begin
        m_st[i] = 0; m_s1[i] = 0; m_s2[i] = 0; m_win[i] = 0;
        m_dir[i] = 0; m_rs[i] = 0; m_cnt[i] = 0; m_ret[i] = 1;
      end
      pv_st = 1; pv_pa = 1; pv_ak = 1;
      return;
    end
    rise_st = start_i && (pv_st == 0);
    rise_pa = pause_i && (pv_pa == 0);
    rise_ak = ack_i && (pv_ak == 0);
    pv_st = int'(start_i); pv_pa = int'(pause_i); pv_ak = int'(ack_i);
    for (int i = 0; i < 2; i++) begin
      m_rs[i] = 0;
      case (m_st[i])
        0: if (rise_st) begin
             m_st[i] = 1; m_s1[i] = 0; m_s2[i] = 0; m_win[i] = 0; m_dir[i] = 0; m_cnt[i] = p_srv[i];
           end
        1: if (rise_pa) begin
             m_st[i] = 4; m_ret[i] = 1;
           end else if (m_cnt[i] == 0) begin
             m_st[i] = 2; m_rs[i] = 1;
           end else if (tick_i) m_cnt[i] = m_cnt[i] - 1;
        2: if (p1_i != p2_i) begin
             if (p1_i) begin a = m_s1[i] + 1; b = m_s2[i]; end
             else      begin a = m_s2[i] + 1; b = m_s1[i]; end
             if (a > p_max[i]) a = p_max[i];
             if (p1_i) m_s1[i] = a; else m_s2[i] = a;
             m_dir[i] = p1_i ? 1 : 0;
             if (a >= p_ws[i] && a - b >= p_wm[i]) begin
               m_st[i] = 3; m_win[i] = p1_i ? 1 : 2; m_cnt[i] = p_ovr[i];
             end else begin
               m_st[i] = 1; m_cnt[i] = p_srv[i];
             end
           end else if (rise_pa) begin
             m_st[i] = 4; m_ret[i] = 2;
           end
        3: if (rise_ak) m_st[i] = 0;
           else if (p_ovr[i] > 0) begin
             if (m_cnt[i] == 0) m_st[i] = 0;
             else if (tick_i) m_cnt[i] = m_cnt[i] - 1;
           end
        4: if (rise_ak) begin
             m_st[i] = 0; m_s1[i] = 0; m_s2[i] = 0; m_win[i] = 0;
           end else if (rise_pa) m_st[i] = m_ret[i];
        default: m_st[i] = 0;
      endcase
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    chk("A.state", a_state, m_st[0]); chk("A.p1", a_s1, m_s1[0]); chk("A.p2", a_s2, m_s2[0]);
    chk("A.winner", a_win, m_win[0]); chk("A.serve_dir", a_dir, m_dir[0]); chk("A.round", a_rs, m_rs[0]);
    chk("B.state", b_state, m_st[1]); chk("B.p1", b_s1, m_s1[1]); chk("B.p2", b_s2, m_s2[1]);
    chk("B.winner", b_win, m_win[1]); chk("B.serve_dir", b_dir, m_dir[1]); chk("B.round", b_rs, m_rs[1]);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic cyc(input bit t, input bit st, input bit pa, input bit ak, input bit q1, input bit q2);
    tick_i = t; start_i = st; pause_i = pa; ack_i = ak; p1_i = q1; p2_i = q2;
    step();
  endtask

  task automatic idle(); cyc(0, 0, 0, 0, 0, 0); endtask

  task automatic serve_a();
    repeat (60) cyc(1, 0, 0, 0, 0, 0);
    idle();
  endtask

  initial begin
    // Reset with start held: releasing reset must not start a game.
    rst_i = 1'b1; start_i = 1'b1;
    step(); step();
    chk("rst_state", a_state, 0); chk("rst_p1", a_s1, 0); chk("rst_winner", a_win, 0);
    chk("rst_B_state", b_state, 0);
    rst_i = 1'b0;
    cyc(0, 1, 0, 0, 0, 0); cyc(0, 1, 0, 0, 0, 0);
    chk("held_start_no_game", a_state, 0);
    idle(); cyc(0, 1, 0, 0, 0, 0);
    chk("start_to_serve", a_state, 1);
    repeat (60) cyc(1, 0, 0, 0, 0, 0);
    chk("serve_after_60_ticks", a_state, 1);
    idle();
    chk("play_after_serve", a_state, 2); chk("round_start_pulse", a_rs, 1);
    idle();
    chk("round_start_one_cycle", a_rs, 0);

    // Three player1 points under the default rule.
    for (int k = 1; k <= 3; k++) begin
      cyc(0, 0, 0, 0, 1, 0);
      chk("p1_score_step", a_s1, k);
      if (k < 3) begin
        chk("serve_after_point", a_state, 1);
        serve_a();
      end
    end
    chk("win_state", a_state, 3); chk("win_winner", a_win, 1); chk("win_serve_dir", a_dir, 1);
    cyc(0, 0, 0, 1, 0, 0);
    chk("ack_to_menu", a_state, 0); chk("menu_hold_p1", a_s1, 3); chk("menu_hold_p2", a_s2, 0);
    idle();

    // Deuce-style play on instance B while A waits in SERVE without ticks.
    cyc(0, 1, 0, 0, 0, 0); idle();
    cyc(0, 0, 0, 0, 1, 0); idle(); cyc(0, 0, 0, 0, 0, 1); idle();
    cyc(0, 0, 0, 0, 1, 0); idle(); cyc(0, 0, 0, 0, 0, 1); idle();
    cyc(0, 0, 0, 0, 1, 0);
    chk("deuce_3_2_serve", b_state, 1); chk("deuce_3_2_p1", b_s1, 3); chk("deuce_3_2_p2", b_s2, 2);
    idle(); cyc(0, 0, 0, 0, 0, 1);
    chk("deuce_3_3_p2", b_s2, 3);
    idle(); cyc(0, 0, 0, 0, 1, 0); idle(); cyc(0, 0, 0, 0, 1, 0);
    chk("deuce_5_3_over", b_state, 3); chk("deuce_winner", b_win, 1); chk("deuce_p1", b_s1, 5);
    chk("A_waits_serve", a_state, 1);
    repeat (60) cyc(1, 0, 0, 0, 0, 0);
    chk("B_no_auto_return", b_state, 3);
    idle();
    chk("A_play_again", a_state, 2);

    // Simultaneous points, then point plus pause.
    cyc(0, 0, 0, 0, 1, 1);
    chk("both_points_state", a_state, 2); chk("both_points_p1", a_s1, 0); chk("both_points_p2", a_s2, 0);
    cyc(0, 0, 1, 0, 0, 1);
    chk("point_beats_pause", a_state, 1); chk("point_beats_pause_p2", a_s2, 1);
    idle();

    // Pause in SERVE freezes the counter at 20.
    repeat (40) cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    chk("serve_pause", a_state, 4);
    idle();
    repeat (50) cyc(1, 0, 0, 0, 0, 0);
    chk("pause_holds", a_state, 4);
    cyc(0, 0, 1, 0, 0, 0);
    chk("resume_serve", a_state, 1);
    idle();
    repeat (20) cyc(1, 0, 0, 0, 0, 0);
    chk("resume_20_ticks", a_state, 1);
    idle();
    chk("resume_play", a_state, 2);
    cyc(0, 0, 1, 0, 0, 0); idle();
    cyc(0, 0, 0, 1, 0, 0);
    chk("abort_menu", a_state, 0); chk("abort_p1", a_s1, 0); chk("abort_p2", a_s2, 0);
    idle();

    // GAME_OVER auto-return after 300 ticks.
    cyc(0, 1, 0, 0, 0, 0); idle();
    serve_a();
    for (int k = 1; k <= 3; k++) begin
      cyc(0, 0, 0, 0, 1, 0);
      if (k < 3) serve_a();
    end
    chk("over_again", a_state, 3);
    repeat (300) cyc(1, 0, 0, 0, 0, 0);
    chk("over_300_ticks", a_state, 3);
    idle();
    chk("auto_return", a_state, 0); chk("auto_return_p1", a_s1, 3);
    chk("B_over_zero_holds", b_state, 3);

    // Reset mid-PLAY.
    cyc(0, 0, 0, 1, 0, 0); idle();
    cyc(0, 1, 0, 0, 0, 0); idle();
    serve_a();
    cyc(0, 0, 0, 0, 1, 0);
    serve_a();
    chk("pre_rst_play", a_state, 2);
    rst_i = 1'b1; step(); rst_i = 1'b0;
    chk("rst_mid_state", a_state, 0); chk("rst_mid_p1", a_s1, 0); chk("rst_mid_dir", a_dir, 0);

    // Randomised stimulus, checked every cycle against the model.
    repeat (8000) begin
      rst_i  = ($urandom_range(0, 399) == 0);
      tick_i = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0)  start_i = ~start_i;
      if ($urandom_range(0, 11) == 0) pause_i = ~pause_i;
      if ($urandom_range(0, 19) == 0) ack_i = ~ack_i;
      p1_i = ($urandom_range(0, 5) == 0);
      p2_i = ($urandom_range(0, 5) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/game_flow_fsm.md
Name: game_flow_fsm

Overview:
- Parametrised top-level game sequencer for the pong logic. It replaces the fixed 3-point MENU/PLAY/GAME_OVER FSM.
- Owns both score registers and applies a configurable win rule: target score plus winning margin.
- Adds a timed SERVE phase, a PAUSE state with resume/abort, and an auto-return from GAME_OVER.
- Sits between the scoring/ball logic (point pulses in) and the ball, pad and render blocks (state, scores, serve info out).

Parameters:
- WIN_SCORE, 3: minimum score needed to win; must be ≤ 2^SCORE_W−1.
- WIN_MARGIN, 1: required lead over the opponent at win time; 1 gives plain first-to-N, 2 gives deuce-style play.
- SCORE_W, 4: width of each score register.
- SERVE_TICKS, 60: timing_tick count spent in SERVE before PLAY.
- OVER_TICKS, 300: timing_tick count before GAME_OVER auto-returns to MENU_START; 0 disables auto-return.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- timing_tick  in  1  one-cycle frame tick
- start  in  1  level button; rising edge starts a game
- pause  in  1  level button; rising edge toggles pause
- ack  in  1  level button; rising edge leaves GAME_OVER or aborts from PAUSE
- point_p1  in  1  one-cycle pulse: player1 scored
- point_p2  in  1  one-cycle pulse: player2 scored
- state  out  3  0=MENU_START, 1=SERVE, 2=PLAY, 3=GAME_OVER, 4=PAUSE
- player1_score  out  SCORE_W  player1 score
- player2_score  out  SCORE_W  player2 score
- winner  out  2  0=none, 1=player1, 2=player2
- serve_dir  out  1  0=ball serves toward player1, 1=toward player2
- round_start  out  1  one-cycle pulse on the SERVE→PLAY transition

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on rst.
- Reset values: state=MENU_START, scores=0, winner=0, serve_dir=0, round_start=0, tick counter=0, saved-return state=SERVE.
- Button edge detectors: start, pause and ack each pass through a registered edge detector. The previous-value flops reset to 1, so a button held through reset does not fire. A rise is the current level 1 with the previous 0. A rise acts in the same cycle it is detected, and all outputs are registered, so an output changes one clk after the edge is seen.
- MENU_START:
  - Scores and winner from the last game are held for display.
  - start rise → SERVE. On this transition: scores←0, winner←0, serve_dir←0, counter←SERVE_TICKS.
  - pause, ack and point pulses are ignored.
- SERVE:
  - If counter==0 → PLAY next clk and round_start pulses for exactly that one cycle. Otherwise counter decrements on each timing_tick.
  - Result: PLAY is entered one clk after the SERVE_TICKS-th tick. With SERVE_TICKS=0, PLAY follows one clk after entry.
  - pause rise → PAUSE; saved state←SERVE; counter frozen.
  - Point pulses are ignored.
- PLAY:
  - Exactly one of point_p1/point_p2 high: the scorer's score +1, saturating at 2^SCORE_W−1.
  - serve_dir is set toward the conceding player: point_p1 sets 1, point_p2 sets 0.
  - Win check uses the post-increment values: scorer ≥ WIN_SCORE and scorer − opponent ≥ WIN_MARGIN, compared unsigned with scorer > opponent.
    - Win → GAME_OVER; winner set; counter←OVER_TICKS.
    - No win → SERVE; counter←SERVE_TICKS.
  - point_p1 and point_p2 high in the same cycle: both ignored, state unchanged.
  - A point pulse takes priority over a pause rise in the same cycle; the pause is dropped.
  - pause rise with no point → PAUSE; saved state←PLAY.
- PAUSE:
  - Scores, counter and serve_dir are frozen; point pulses are ignored.
  - pause rise → saved state, counter unchanged.
  - ack rise → MENU_START with scores←0 and winner←0 (abort).
  - If pause and ack rise in the same cycle, ack wins.
- GAME_OVER:
  - Scores and winner are held.
  - ack rise → MENU_START.
  - If OVER_TICKS>0: counter decrements on each timing_tick; counter==0 → MENU_START.
  - pause and point pulses are ignored.
- Counter width is $clog2(max(SERVE_TICKS,OVER_TICKS)+1). Illegal state encodings (5–7) → MENU_START next clk.
- rst asserted in any state overrides every other input and returns all outputs to their reset values on the next clk.

Test Plan:
1. Reset with start held high, then released, then pulsed again: no start on release; start pulse → state=1 (SERVE). After 60 timing_ticks plus 1 clk → state=2 (PLAY) with a one-cycle round_start.
2. Defaults, 3 point_p1 pulses, each followed by its serve: scores go 1-0, 2-0, 3-0. After the third → state=3, winner=1, serve_dir=1. ack rise → state=0 with scores still shown as 3-0.
3. WIN_MARGIN=2, WIN_SCORE=3, score 2-2: point_p1 gives 3-2 and SERVE, not a win. point_p2 gives 3-3. point_p1, point_p1 gives 5-3 → GAME_OVER, winner=1.
4. In PLAY, point_p1 and point_p2 together → scores and state unchanged. In PLAY, point_p2 with a pause rise in the same cycle → score 0-1, state=SERVE, no PAUSE.
5. Pause during SERVE with counter=20: 50 timing_ticks while in PAUSE → counter stays 20. pause rise → SERVE; 20 ticks → PLAY. A second game: pause, then ack → MENU_START with scores 0-0.
6. GAME_OVER with OVER_TICKS=300 and no ack → MENU_START one clk after the 300th tick. OVER_TICKS=0 → GAME_OVER holds indefinitely. rst mid-PLAY → all reset values next clk.
